// File: rtl/vga_vram_scanout_pkg.sv
// Shared timing constants, widths and types for the VGA VRAM scan-out path.
// Default timing is 640x480@60 with a 25 MHz pixel rate derived from a 50 MHz clock.
package vga_vram_scanout_pkg;

  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam int CELL_SHIFT = 3;
  localparam int PIPE_DEF   = 2;

  localparam int VRAM_AW = 13;
  localparam int RGB_W   = 3;
  localparam int CNT_W   = 10;
  localparam int COL_W   = 7;
  localparam int ROW_W   = 6;

  // One slot of the sync/blank delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } syncStage_t;

  localparam syncStage_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};

  // VRAM cell address {row, col} for a pixel position.
  function automatic logic [VRAM_AW-1:0] cellAddr(input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] v,
                                                  input int shift);
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    col = COL_W'(h >> shift);
    row = ROW_W'(v >> shift);
    return {row, col};
  endfunction

endpackage

// File: rtl/vga_vram_scanout_timing_counter.sv
// Pixel strobe, raster counters and undelayed (stage 0) sync/blank decode.
// Counter order per line and frame: display, front porch, sync, back porch.
import vga_vram_scanout_pkg::*;

module vga_timing_counter #(
  parameter int H_DISP_P = H_DISP,
  parameter int H_FP_P   = H_FP,
  parameter int H_SYNC_P = H_SYNC,
  parameter int H_BP_P   = H_BP,
  parameter int V_DISP_P = V_DISP,
  parameter int V_FP_P   = V_FP,
  parameter int V_SYNC_P = V_SYNC,
  parameter int V_BP_P   = V_BP
) (
  input  logic             Clock,
  input  logic             Reset_n,
  output logic             pixelEn,
  output logic [CNT_W-1:0] hCnt,
  output logic [CNT_W-1:0] vCnt,
  output syncStage_t       stage0,
  output logic             vBlank,
  output logic             frameStart
);

  localparam int HT = H_DISP_P + H_FP_P + H_SYNC_P + H_BP_P;
  localparam int VT = V_DISP_P + V_FP_P + V_SYNC_P + V_BP_P;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_DISP_P);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_DISP_P);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_DISP_P + H_FP_P);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_DISP_P + H_FP_P + H_SYNC_P);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_DISP_P + V_FP_P);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_DISP_P + V_FP_P + V_SYNC_P);

  logic armed;

  // armed holds the strobe off for one clock so its first high lands on the 2nd edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      armed   <= 1'b0;
      pixelEn <= 1'b0;
    end else begin
      armed   <= 1'b1;
      pixelEn <= armed & ~pixelEn;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (pixelEn) begin
      if (hCnt == H_LAST) begin
        hCnt <= '0;
        vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
      end else begin
        hCnt <= hCnt + 1'b1;
      end
    end
  end

  always_comb begin
    stage0       = SYNC_IDLE;
    stage0.hs    = !((hCnt >= H_SYNC_BEG) && (hCnt < H_SYNC_END));
    stage0.vs    = !((vCnt >= V_SYNC_BEG) && (vCnt < V_SYNC_END));
    stage0.blank = (hCnt >= H_VIS) || (vCnt >= V_VIS);
  end

  assign vBlank     = (vCnt >= V_VIS);
  assign frameStart = pixelEn && (hCnt == '0) && (vCnt == '0);

endmodule

// File: rtl/vga_vram_scanout.sv
// VGA scan-out: issues VRAM cell reads and delays sync/blank so colour and sync leave aligned.
// Address register, PIPE-deep sync delay line and masked RGB output register.
import vga_vram_scanout_pkg::*;

module vga_vram_scanout #(
  parameter int H_DISP_P     = H_DISP,
  parameter int H_FP_P       = H_FP,
  parameter int H_SYNC_P     = H_SYNC,
  parameter int H_BP_P       = H_BP,
  parameter int V_DISP_P     = V_DISP,
  parameter int V_FP_P       = V_FP,
  parameter int V_SYNC_P     = V_SYNC,
  parameter int V_BP_P       = V_BP,
  parameter int CELL_SHIFT_P = CELL_SHIFT,
  parameter int PIPE         = PIPE_DEF
) (
  input  logic               Clock,
  input  logic               Reset_n,
  output logic [VRAM_AW-1:0] oVramAddr,
  input  logic [RGB_W-1:0]   iVramData,
  output logic [RGB_W-1:0]   oRGB,
  output logic               oHSync,
  output logic               oVSync,
  output logic               oPixelEn,
  output logic               oVBlank,
  output logic               oFrameStart
);

  logic             pixelEn;
  logic [CNT_W-1:0] hCnt;
  logic [CNT_W-1:0] vCnt;
  syncStage_t       stage0;

  syncStage_t [PIPE:1]                syncPipe;
  logic       [PIPE-1:1][RGB_W-1:0]   rgbPipe;

  vga_timing_counter #(
    .H_DISP_P (H_DISP_P), .H_FP_P (H_FP_P), .H_SYNC_P (H_SYNC_P), .H_BP_P (H_BP_P),
    .V_DISP_P (V_DISP_P), .V_FP_P (V_FP_P), .V_SYNC_P (V_SYNC_P), .V_BP_P (V_BP_P)
  ) uTiming (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .pixelEn    (pixelEn),
    .hCnt       (hCnt),
    .vCnt       (vCnt),
    .stage0     (stage0),
    .vBlank     (oVBlank),
    .frameStart (oFrameStart)
  );

  // Blank pixels read cell 0 so the address never leaves the visible cell grid.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)     oVramAddr <= '0;
    else if (pixelEn) oVramAddr <= stage0.blank ? '0 : cellAddr(hCnt, vCnt, CELL_SHIFT_P);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)     syncPipe[1] <= SYNC_IDLE;
    else if (pixelEn) syncPipe[1] <= stage0;
  end

  for (genvar g = 2; g <= PIPE; g++) begin : gSyncPipe
    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n)     syncPipe[g] <= SYNC_IDLE;
      else if (pixelEn) syncPipe[g] <= syncPipe[g-1];
    end
  end

  // Data for the address issued one strobe earlier is masked at capture, so X never escapes.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)     rgbPipe[1] <= '0;
    else if (pixelEn) rgbPipe[1] <= syncPipe[1].blank ? '0 : iVramData;
  end

  for (genvar g = 2; g <= PIPE - 1; g++) begin : gRgbPipe
    always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n)     rgbPipe[g] <= '0;
      else if (pixelEn) rgbPipe[g] <= rgbPipe[g-1];
    end
  end

  assign oRGB     = rgbPipe[PIPE-1];
  assign oHSync   = syncPipe[PIPE].hs;
  assign oVSync   = syncPipe[PIPE].vs;
  assign oPixelEn = pixelEn;

endmodule

// File: tb/tb_vga_vram_scanout.sv
// Directed bench: a full-size instance for line-level timing, a reduced-timing instance for frame-level checks.
module tb_vga_vram_scanout;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  int   edgeCnt = 0;
  int   pattern = 0;
  int   nAsserts = 0;
  int   nFails = 0;

  logic [12:0] fAddr, sAddr;
  logic [2:0]  fData, sData, fRgb, sRgb;
  logic        fHs, fVs, fPe, fVb, fFs;
  logic        sHs, sVs, sPe, sVb, sFs;

  always #10 Clock = ~Clock;

  // Posedges since the last reset release.
  always @(posedge Clock or negedge Reset_n)
    if (!Reset_n) edgeCnt <= 0;
    else          edgeCnt <= edgeCnt + 1;

  vga_vram_scanout uFull (
    .Clock (Clock), .Reset_n (Reset_n), .oVramAddr (fAddr), .iVramData (fData),
    .oRGB (fRgb), .oHSync (fHs), .oVSync (fVs), .oPixelEn (fPe),
    .oVBlank (fVb), .oFrameStart (fFs)
  );

  // Reduced timing: 64x40 visible, 96x48 total, sync at h 72..87 and v 42..43.
  vga_vram_scanout #(
    .H_DISP_P (64), .H_FP_P (8), .H_SYNC_P (16), .H_BP_P (8),
    .V_DISP_P (40), .V_FP_P (2), .V_SYNC_P (2),  .V_BP_P (4)
  ) uSmall (
    .Clock (Clock), .Reset_n (Reset_n), .oVramAddr (sAddr), .iVramData (sData),
    .oRGB (sRgb), .oHSync (sHs), .oVSync (sVs), .oPixelEn (sPe),
    .oVBlank (sVb), .oFrameStart (sFs)
  );

  function automatic logic [2:0] vramModel(input logic [12:0] a, input int mode);
    logic [7:0] s;
    s = {2'b00, a[12:7]} + {1'b0, a[6:0]};
    case (mode)
      0:       return s[2:0];
      1:       return 3'b111;
      default: return (a == 13'd0) ? 3'bxxx : 3'b111;
    endcase
  endfunction

  // One-clock read latency VRAM models.
  always @(posedge Clock) begin
    fData <= vramModel(fAddr, pattern);
    sData <= vramModel(sAddr, pattern);
  end

  task automatic gotoEdge(input int e);
    while (edgeCnt < e) @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic seen [0:8191];

  initial begin
    int width;
    int kPix, kAdr, kCnt, x, y, xa, ya, xc, yc;
    logic [12:0] expAddr;
    int rgbErrs, addrErrs, syncErrs, vbErrs, peErrs, fsErrs;
    int lit, hsLow, vsLow, vbHigh, peHigh, fsCnt, distinct, maxCol, maxRow, vsFall;
    logic prevVs;

    // Power-on reset
    repeat (3) @(negedge Clock);
    check("rst_hs", fHs, 1);  check("rst_vs", fVs, 1);   check("rst_rgb", fRgb, 0);
    check("rst_pe", fPe, 0);  check("rst_vb", fVb, 0);   check("rst_fs", fFs, 0);
    check("rst_addr", fAddr, 0); check("rst_s_hs", sHs, 1); check("rst_s_vb", sVb, 0);
    Reset_n = 1'b1;

    gotoEdge(1); check("pe_edge1", fPe, 0);
    gotoEdge(2); check("pe_edge2", fPe, 1); check("fs_edge2", fFs, 1);
    gotoEdge(3); check("pe_edge3", fPe, 0); check("fs_edge3", fFs, 0);
    gotoEdge(1316); check("hs_before_fall", fHs, 1);
    gotoEdge(1317); check("hs_fall", fHs, 0);
    gotoEdge(1400); check("hs_mid", fHs, 0); check("pe_mid", fPe, 1);

    // Mid-line reset pulse, 3 clocks low
    Reset_n = 1'b0;
    #1;
    check("arst_hs", fHs, 1); check("arst_pe", fPe, 0); check("arst_rgb", fRgb, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("rstlow_hs", fHs, 1); check("rstlow_vs", fVs, 1); check("rstlow_rgb", fRgb, 0);
    end
    Reset_n = 1'b1;

    // Restart at (0,0); pixel n shows after edge 2n+5, its address after 2n+3
    gotoEdge(2);    check("restart_fs", fFs, 1);
    gotoEdge(17);   check("addr_px7", fAddr, 0);
    gotoEdge(19);   check("addr_px8", fAddr, 1);  check("rgb_px7", fRgb, 0);
    gotoEdge(20);   check("rgb_px8_early", fRgb, 0);
    gotoEdge(21);   check("rgb_px8", fRgb, 1);
    gotoEdge(1281); check("addr_px639", fAddr, 79);
    gotoEdge(1283); check("addr_px640", fAddr, 0); check("rgb_px639", fRgb, 7);
    gotoEdge(1285); check("rgb_px640_blank", fRgb, 0);

    gotoEdge(1316); check("hs_pre", fHs, 1);
    gotoEdge(1317);
    width = 0;
    while (fHs === 1'b0 && width < 4000) begin width++; gotoEdge(edgeCnt + 1); end
    check("hs_low_clocks", width, 192);
    width = 0;
    while (fHs === 1'b1 && width < 4000) begin width++; gotoEdge(edgeCnt + 1); end
    check("hs_high_clocks", width, 1408);
    check("hs_period_edge", edgeCnt, 2917);

    gotoEdge(12821); check("rgb_line8_px8", fRgb, 2);

    // Reduced instance: last visible pixel (63,39) of frame 1, then first blank pixel
    gotoEdge(16835); check("s_rgb_last_vis", sRgb, 3);
    gotoEdge(16837); check("s_rgb_after_last", sRgb, 0);
    pattern = 1;
    gotoEdge(18435); check("s_rgb_vblank_white", sRgb, 0);

    // One full reduced frame checked sample by sample against a position model
    rgbErrs = 0; addrErrs = 0; syncErrs = 0; vbErrs = 0; peErrs = 0; fsErrs = 0;
    lit = 0; hsLow = 0; vsLow = 0; vbHigh = 0; peHigh = 0; fsCnt = 0;
    distinct = 0; maxCol = 0; maxRow = 0; vsFall = -1; prevVs = 1'b1;
    for (int i = 0; i < 8192; i++) seen[i] = 1'b0;
    for (int e = 18437; e <= 27652; e++) begin
      gotoEdge(e);
      kPix = (e - 5) / 2;  x  = kPix % 96;  y  = (kPix / 96) % 48;
      kAdr = (e - 3) / 2;  xa = kAdr % 96;  ya = (kAdr / 96) % 48;
      kCnt = (e - 1) / 2;  xc = kCnt % 96;  yc = (kCnt / 96) % 48;
      if (e == 18437) check("s_first_white", sRgb, 7);
      if (sRgb !== ((x < 64 && y < 40) ? 3'd7 : 3'd0)) rgbErrs++;
      expAddr = (xa < 64 && ya < 40) ? {6'(ya >> 3), 7'(xa >> 3)} : 13'd0;
      if (sAddr !== expAddr) addrErrs++;
      if (sHs !== !(x >= 72 && x < 88) || sVs !== !(y >= 42 && y < 44)) syncErrs++;
      if (sVb !== (yc >= 40)) vbErrs++;
      if (sPe !== (e % 2 == 0)) peErrs++;
      if (sFs !== (e % 2 == 0 && xc == 0 && yc == 0)) fsErrs++;
      if (sRgb !== 3'd0) lit++;
      if (sHs === 1'b0) hsLow++;
      if (sVs === 1'b0) vsLow++;
      if (sVs === 1'b0 && prevVs === 1'b1 && vsFall < 0) vsFall = e;
      prevVs = sVs;
      if (sVb === 1'b1) vbHigh++;
      if (sPe === 1'b1) peHigh++;
      if (sFs === 1'b1) fsCnt++;
      if (!seen[sAddr]) begin seen[sAddr] = 1'b1; distinct++; end
      if (int'(sAddr[6:0]) > maxCol) maxCol = int'(sAddr[6:0]);
      if (int'(sAddr[12:7]) > maxRow) maxRow = int'(sAddr[12:7]);
    end
    check("s_rgb_errs", rgbErrs, 0);   check("s_addr_errs", addrErrs, 0);
    check("s_sync_errs", syncErrs, 0); check("s_vblank_errs", vbErrs, 0);
    check("s_pe_errs", peErrs, 0);     check("s_fs_errs", fsErrs, 0);
    check("s_lit_clocks", lit, 5120);  check("s_hs_low_clocks", hsLow, 1536);
    check("s_vs_low_clocks", vsLow, 384); check("s_vs_fall_edge", vsFall, 26501);
    check("s_vblank_clocks", vbHigh, 1536); check("s_pe_strobes", peHigh, 4608);
    check("s_frame_starts", fsCnt, 1); check("s_distinct_addr", distinct, 40);
    check("s_max_col", maxCol, 7);     check("s_max_row", maxRow, 4);

    // Undefined read data on cell 0 must never reach the pins during blanking
    pattern = 2;
    gotoEdge(27669); check("s_x_visible_px", sRgb, 7);
    gotoEdge(28753); check("s_x_blank_px", sRgb, 0);

    // Next frame's vsync pulse: one frame (9216 clocks) after the first
    gotoEdge(35716); check("s_vs_pre", sVs, 1);
    gotoEdge(35717); check("s_vs_fall", sVs, 0);
    gotoEdge(36100); check("s_vs_last_low", sVs, 0);
    gotoEdge(36101); check("s_vs_rise", sVs, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
